// File: rtl/bean_control_if.sv
// Control-to-datapath bundle for the BEAN-1 control FSM.
// master: control unit (drives strobes/selects); slave: datapath + memory.
interface bean_control_if;
  logic [31:0] instr;
  logic        jump;
  logic        mem_ready;
  logic        reg_WE;
  logic        rs1_SEL;
  logic        rs2_SEL;
  logic        addrs_SEL;
  logic        pc_EN;
  logic        instr_EN;
  logic        ALU_mem_EN;
  logic        mem_in_EN;
  logic [1:0]  reg_SEL;
  logic [1:0]  pc_SEL;
  logic [2:0]  imm_SEL;
  logic [3:0]  ALU_MODE;
  logic        mem_RE;
  logic        mem_WE;
  logic [2:0]  mem_size;
  logic        halted;

  modport master (
    input  instr, jump, mem_ready,
    output reg_WE, rs1_SEL, rs2_SEL, addrs_SEL,
    output pc_EN, instr_EN, ALU_mem_EN, mem_in_EN,
    output reg_SEL, pc_SEL, imm_SEL, ALU_MODE,
    output mem_RE, mem_WE, mem_size, halted
  );

  modport slave (
    output instr, jump, mem_ready,
    input  reg_WE, rs1_SEL, rs2_SEL, addrs_SEL,
    input  pc_EN, instr_EN, ALU_mem_EN, mem_in_EN,
    input  reg_SEL, pc_SEL, imm_SEL, ALU_MODE,
    input  mem_RE, mem_WE, mem_size, halted
  );
endinterface

// File: rtl/bean_control.sv
// BEAN-1 multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/TRAP.
// Ports: clk, reset (sync, active-high), bus (bean_control_if.master).
module bean_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  bean_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_TRAP
  } state_t;

  typedef struct packed {
    logic       reg_WE;
    logic       rs1_SEL;
    logic       rs2_SEL;
    logic       addrs_SEL;
    logic       pc_EN;
    logic       instr_EN;
    logic       ALU_mem_EN;
    logic       mem_in_EN;
    logic [1:0] reg_SEL;
    logic [1:0] pc_SEL;
    logic [2:0] imm_SEL;
    logic [3:0] ALU_MODE;
    logic       mem_RE;
    logic       mem_WE;
    logic [2:0] mem_size;
    logic       halted;
  } ctl_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUI   = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  ctl_t                 o, ctl;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_ld, is_st, is_op, is_opi, is_lui;
  logic is_aui, is_jal, is_jalr, is_br, is_fence;
  logic op_ok, opi_ok, br_ok, to_exec, tmo;
  logic [3:0] alu_rr, alu_br;
  logic unused;

  assign opc = bus.instr[6:0];
  assign f3  = bus.instr[14:12];
  assign f7  = bus.instr[31:25];
  assign unused = ^{bus.instr[24:15], bus.instr[11:7]};

  assign is_ld    = opc == OPC_LOAD;
  assign is_st    = opc == OPC_STORE;
  assign is_op    = opc == OPC_OP;
  assign is_opi   = opc == OPC_OPI;
  assign is_lui   = opc == OPC_LUI;
  assign is_aui   = opc == OPC_AUI;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BR;
  assign is_fence = opc == OPC_FENCE;

  // alternate funct7 only valid for SUB and SRA
  assign op_ok = (f7 == 7'b0000000) |
                 ((f7 == 7'b0100000) &
                  ((f3 == 3'b000) | (f3 == 3'b101)));
  assign opi_ok = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                  (f3 == 3'b101) ? ((f7 == 7'b0000000) |
                                    (f7 == 7'b0100000)) :
                  1'b1;
  assign br_ok = f3[2:1] != 2'b01;

  assign to_exec = (is_op & op_ok) | (is_opi & opi_ok) |
                   (is_br & br_ok) | is_lui | is_aui |
                   is_jal | is_jalr | is_fence;

  assign tmo = (MEM_TIMEOUT != 0) &&
               (cnt_q == TIMEOUT_W'(MEM_TIMEOUT));

  // OP-IMM never subtracts; f7[5] only selects SUB on OP
  always_comb begin
    alu_rr = 4'd0;
    unique case (f3)
      3'b000: alu_rr = (is_op & f7[5]) ? 4'd1 : 4'd0;
      3'b001: alu_rr = 4'd2;
      3'b010: alu_rr = 4'd3;
      3'b011: alu_rr = 4'd4;
      3'b100: alu_rr = 4'd5;
      3'b101: alu_rr = f7[5] ? 4'd7 : 4'd6;
      3'b110: alu_rr = 4'd8;
      3'b111: alu_rr = 4'd9;
      default: alu_rr = 4'd0;
    endcase
  end

  always_comb begin
    alu_br = 4'd0;
    unique case (f3)
      3'b000: alu_br = 4'd10;
      3'b001: alu_br = 4'd11;
      3'b100: alu_br = 4'd3;
      3'b101: alu_br = 4'd12;
      3'b110: alu_br = 4'd4;
      3'b111: alu_br = 4'd13;
      default: alu_br = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    o       = '0;
    unique case (state_q)
      S_FETCH: begin
        o.addrs_SEL = 1'b1;
        o.mem_RE    = 1'b1;
        o.mem_in_EN = 1'b1;
        o.mem_size  = 3'b010;
        if (bus.mem_ready) begin
          o.instr_EN = 1'b1;
          state_d    = S_DECODE;
        end else if (tmo) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (is_ld | is_st) state_d = S_MEM;
        else if (to_exec)  state_d = S_EXEC;
        else               state_d = S_TRAP;
      end
      S_EXEC: begin
        o.pc_EN = 1'b1;
        state_d = S_FETCH;
        unique case (1'b1)
          is_op: begin
            o.ALU_MODE = alu_rr;
            o.reg_SEL  = 2'd1;
            o.reg_WE   = 1'b1;
          end
          is_opi: begin
            o.rs2_SEL  = 1'b1;
            o.ALU_MODE = alu_rr;
            o.reg_SEL  = 2'd1;
            o.reg_WE   = 1'b1;
          end
          is_lui: begin
            o.imm_SEL = 3'd3;
            o.reg_SEL = 2'd2;
            o.reg_WE  = 1'b1;
          end
          is_aui: begin
            o.rs1_SEL = 1'b1;
            o.rs2_SEL = 1'b1;
            o.imm_SEL = 3'd3;
            o.reg_SEL = 2'd1;
            o.reg_WE  = 1'b1;
          end
          is_jal: begin
            o.imm_SEL = 3'd4;
            o.reg_SEL = 2'd3;
            o.reg_WE  = 1'b1;
            o.pc_SEL  = 2'd2;
          end
          is_jalr: begin
            o.rs2_SEL = 1'b1;
            o.reg_SEL = 2'd3;
            o.reg_WE  = 1'b1;
            o.pc_SEL  = 2'd1;
          end
          is_br: begin
            o.imm_SEL  = 3'd2;
            o.ALU_MODE = alu_br;
            o.pc_SEL   = bus.jump ? 2'd2 : 2'd0;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        o.rs2_SEL  = 1'b1;
        o.mem_size = f3;
        if (is_st) begin
          o.imm_SEL    = 3'd1;
          o.ALU_mem_EN = 1'b1;
          o.mem_WE     = 1'b1;
        end else begin
          o.mem_RE    = 1'b1;
          o.mem_in_EN = 1'b1;
        end
        if (bus.mem_ready) begin
          o.pc_EN  = 1'b1;
          o.reg_WE = ~is_st;
          state_d  = S_FETCH;
        end else if (tmo) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TRAP: o.halted = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  assign ctl = reset ? '0 : o;

  assign bus.reg_WE     = ctl.reg_WE;
  assign bus.rs1_SEL    = ctl.rs1_SEL;
  assign bus.rs2_SEL    = ctl.rs2_SEL;
  assign bus.addrs_SEL  = ctl.addrs_SEL;
  assign bus.pc_EN      = ctl.pc_EN;
  assign bus.instr_EN   = ctl.instr_EN;
  assign bus.ALU_mem_EN = ctl.ALU_mem_EN;
  assign bus.mem_in_EN  = ctl.mem_in_EN;
  assign bus.reg_SEL    = ctl.reg_SEL;
  assign bus.pc_SEL     = ctl.pc_SEL;
  assign bus.imm_SEL    = ctl.imm_SEL;
  assign bus.ALU_MODE   = ctl.ALU_MODE;
  assign bus.mem_RE     = ctl.mem_RE;
  assign bus.mem_WE     = ctl.mem_WE;
  assign bus.mem_size   = ctl.mem_size;
  assign bus.halted     = ctl.halted;

endmodule

// File: tb/tb_bean_control.sv
// Self-checking bench for bean_control: directed plan steps plus
// random instruction streams against an instruction-level model.
module tb_bean_control;

  localparam int TMO = 4;

  typedef struct packed {
    logic       reg_WE;
    logic       rs1_SEL;
    logic       rs2_SEL;
    logic       addrs_SEL;
    logic       pc_EN;
    logic       instr_EN;
    logic       ALU_mem_EN;
    logic       mem_in_EN;
    logic [1:0] reg_SEL;
    logic [1:0] pc_SEL;
    logic [2:0] imm_SEL;
    logic [3:0] ALU_MODE;
    logic       mem_RE;
    logic       mem_WE;
    logic [2:0] mem_size;
    logic       halted;
  } ctl_t;

  typedef enum int { K_EXEC, K_LOAD, K_STORE, K_TRAP } kind_t;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;
  ctl_t obs;

  bean_control_if bus ();

  bean_control #(
    .MEM_TIMEOUT(TMO),
    .TIMEOUT_W  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.reg_WE, bus.rs1_SEL, bus.rs2_SEL,
                bus.addrs_SEL, bus.pc_EN, bus.instr_EN,
                bus.ALU_mem_EN, bus.mem_in_EN, bus.reg_SEL,
                bus.pc_SEL, bus.imm_SEL, bus.ALU_MODE,
                bus.mem_RE, bus.mem_WE, bus.mem_size,
                bus.halted};

  // ALU mode per funct3 for register ops, and for branches
  // (-1 marks the funct3 values that are not branches).
  int rr_mode [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  int br_mode [8] = '{10, 11, -1, -1, 3, 12, 4, 13};

  function automatic kind_t kind_of(logic [31:0] i);
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    case (i[6:0])
      7'h03: return K_LOAD;
      7'h23: return K_STORE;
      7'h33: begin
        if (f7 == 7'h00) return K_EXEC;
        if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) return K_EXEC;
        return K_TRAP;
      end
      7'h13: begin
        if (f3 == 1 && f7 != 7'h00) return K_TRAP;
        if (f3 == 5 && f7 != 7'h00 && f7 != 7'h20) return K_TRAP;
        return K_EXEC;
      end
      7'h63: return (br_mode[f3] < 0) ? K_TRAP : K_EXEC;
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F: return K_EXEC;
      default: return K_TRAP;
    endcase
  endfunction

  function automatic ctl_t fetch_exp(logic rdy);
    ctl_t e = '0;
    e.addrs_SEL = 1;
    e.mem_RE    = 1;
    e.mem_in_EN = 1;
    e.mem_size  = 3'b010;
    e.instr_EN  = rdy;
    return e;
  endfunction

  function automatic ctl_t exec_exp(logic [31:0] i, logic j);
    ctl_t e = '0;
    int   m = rr_mode[i[14:12]];
    if (i[14:12] == 5 && i[30]) m = 7;
    e.pc_EN = 1;
    case (i[6:0])
      7'h33: begin
        if (i[14:12] == 0 && i[30]) m = 1;
        e.ALU_MODE = 4'(m);
        e.reg_SEL = 1;
        e.reg_WE = 1;
      end
      7'h13: begin
        e.rs2_SEL = 1;
        e.ALU_MODE = 4'(m);
        e.reg_SEL = 1;
        e.reg_WE = 1;
      end
      7'h37: begin
        e.imm_SEL = 3;
        e.reg_SEL = 2;
        e.reg_WE = 1;
      end
      7'h17: begin
        e.rs1_SEL = 1;
        e.rs2_SEL = 1;
        e.imm_SEL = 3;
        e.reg_SEL = 1;
        e.reg_WE = 1;
      end
      7'h6F: begin
        e.imm_SEL = 4;
        e.reg_SEL = 3;
        e.reg_WE = 1;
        e.pc_SEL = 2;
      end
      7'h67: begin
        e.rs2_SEL = 1;
        e.reg_SEL = 3;
        e.reg_WE = 1;
        e.pc_SEL = 1;
      end
      7'h63: begin
        e.imm_SEL = 2;
        e.ALU_MODE = 4'(br_mode[i[14:12]]);
        e.pc_SEL = j ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t mem_exp(logic [31:0] i, logic rdy);
    ctl_t e = '0;
    e.rs2_SEL  = 1;
    e.mem_size = i[14:12];
    e.pc_EN    = rdy;
    if (kind_of(i) == K_STORE) begin
      e.imm_SEL = 1;
      e.ALU_mem_EN = 1;
      e.mem_WE = 1;
    end else begin
      e.mem_RE = 1;
      e.mem_in_EN = 1;
      e.reg_WE = rdy;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input ctl_t e);
    @(negedge clk);
    nvec++;
    assert (obs === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic trap_seq();
    ctl_t h = '0;
    h.halted = 1;
    for (int n = 0; n < 3; n++) begin
      bus.mem_ready = 1'($urandom);
      chk("trap", h);
    end
    reset = 1;
    chk("trap_reset", '0);
    reset = 0;
  endtask

  // fw/mw: cycles with mem_ready low before the ready cycle in
  // fetch/mem; more than TMO low cycles means a timeout trap.
  task automatic run_instr(input logic [31:0] i, input logic j,
                           input int fw, input int mw);
    kind_t k;
    for (int n = 0; n <= TMO; n++) begin
      bus.mem_ready = (n == fw);
      chk("fetch", fetch_exp(bus.mem_ready));
      if (bus.mem_ready) break;
      if (n == TMO) begin
        trap_seq();
        return;
      end
    end
    bus.instr = i;
    bus.jump = j;
    bus.mem_ready = 1'($urandom);
    chk("decode", '0);
    k = kind_of(i);
    if (k == K_EXEC) begin
      chk("exec", exec_exp(i, j));
    end else if (k == K_TRAP) begin
      trap_seq();
    end else begin
      for (int n = 0; n <= TMO; n++) begin
        bus.mem_ready = (n == mw);
        chk("mem", mem_exp(i, bus.mem_ready));
        if (bus.mem_ready) break;
        if (n == TMO) trap_seq();
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r = $urandom;
    int p = $urandom_range(0, 13);
    ops = '{7'h03, 7'h23, 7'h33, 7'h33, 7'h13, 7'h13,
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h0F};
    if (p < 12) r[6:0] = ops[p];
    else if (p == 12) r[6:0] = 7'h73;
    if ((r[6:0] == 7'h33 || r[6:0] == 7'h13) &&
        $urandom_range(0, 3) != 0)
      r[31:25] = r[31] ? 7'h20 : 7'h00;
    return r;
  endfunction

  initial begin
    bus.instr = '0;
    bus.jump = 0;
    bus.mem_ready = 1;
    reset = 1;
    #1;
    chk("reset0", '0);
    chk("reset1", '0);
    reset = 0;

    run_instr(32'h00208033, 0, 0, 0);
    run_instr(32'h00208463, 1, 0, 0);
    run_instr(32'h00208463, 0, 0, 0);
    run_instr(32'h0020A223, 0, 0, 3);
    run_instr(32'h0000A103, 0, 1, 0);
    run_instr(32'h0000A103, 0, 0, 99);
    run_instr(32'h00000073, 0, 0, 0);
    run_instr(32'hFFFFFFFF, 0, 0, 0);
    run_instr(32'h40208033, 0, 2, 0);
    run_instr(32'h00000013, 0, 99, 0);

    for (int n = 0; n < 200; n++)
      run_instr(rand_instr(), 1'($urandom),
                $urandom_range(0, 5), $urandom_range(0, 5));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bean_control.md
Name: bean_control

Overview:
- Multi-cycle control FSM for the BEAN-1 RV32I core.
- Sits directly upstream of the datapath and drives every datapath select and enable from the registered instruction and the ALU `jump` bit.
- Also sequences memory read and write strobes, with a ready handshake and a timeout.
- Halts in a trap state on illegal instructions, ECALL/EBREAK, or a memory timeout.

Parameters:
- MEM_TIMEOUT, 255: maximum number of cycles waited for mem_ready in one access; 0 disables the timeout.
- TIMEOUT_W, 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^TIMEOUT_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  registered instruction from the datapath.
- jump  in  1  ALU result bit 0 (branch compare outcome).
- mem_ready  in  1  memory completes the current access this cycle.
- reg_WE  out  1  register file write enable.
- rs1_SEL  out  1  0=rs1 data, 1=pc.
- rs2_SEL  out  1  0=rs2 data, 1=ExtImm.
- addrs_SEL  out  1  0=ALU result, 1=pc.
- pc_EN, instr_EN  out  1 each  PC and instruction register load enables.
- ALU_mem_EN, mem_in_EN  out  1 each  data bus tristate drivers (rs2 onto bus; memory onto bus).
- reg_SEL  out  2  0=data bus, 1=ALU, 2=ExtImm, 3=pc+4.
- pc_SEL  out  2  0=pc+4, 1=ALU, 2=pc+imm; 3 is never driven.
- imm_SEL  out  3  0=I, 1=S, 2=B, 3=U, 4=J.
- ALU_MODE  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 EQ, 11 NE, 12 GE, 13 GEU.
- mem_RE, mem_WE  out  1 each  memory read and write strobes.
- mem_size  out  3  funct3 of the load/store; 3'b010 during fetch.
- halted  out  1  high while in TRAP.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, TRAP. State and wait counter are registered; all outputs are combinational from state and instr.
- Default output value in every state is 0 for all strobes, selects and modes.
- reset=1: next state FETCH, counter=0. While reset is high all outputs are forced to 0, overriding FETCH.
- FETCH:
  - Drives addrs_SEL=1, mem_RE=1, mem_in_EN=1, mem_size=010.
  - instr_EN=1 only in the cycle mem_ready=1; then go to DECODE.
  - Otherwise stay in FETCH and increment the counter.
- DECODE: one cycle with no strobes. Next state by opcode:
  - LOAD (0000011) or STORE (0100011): MEM.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, MISC-MEM: EXEC.
  - Anything else, or SYSTEM: TRAP.
  - Illegal funct3/funct7 combinations also go to TRAP: OP with funct7 other than 0000000/0100000; SUB/SRA pattern on a non-ADD/SR funct3; BRANCH funct3 010 or 011; OP-IMM shifts with bad funct7.
- EXEC: one cycle; always pc_EN=1; next state FETCH. Per instruction:
  - OP: rs2_SEL=0, ALU_MODE from funct3/funct7, reg_SEL=1, reg_WE=1, pc_SEL=0.
  - OP-IMM: as OP but rs2_SEL=1, imm_SEL=0, no SUB.
  - LUI: imm_SEL=3, reg_SEL=2, reg_WE=1, pc_SEL=0.
  - AUIPC: rs1_SEL=1, rs2_SEL=1, imm_SEL=3, ADD, reg_SEL=1, reg_WE=1, pc_SEL=0.
  - JAL: imm_SEL=4, reg_SEL=3, reg_WE=1, pc_SEL=2.
  - JALR: rs2_SEL=1, imm_SEL=0, ADD, reg_SEL=3, reg_WE=1, pc_SEL=1.
  - BRANCH: rs2_SEL=0, imm_SEL=2; ALU_MODE is EQ/NE/SLT/GE/SLTU/GEU for funct3 000/001/100/101/110/111; pc_SEL=2 if jump else 0; reg_WE=0.
  - MISC-MEM (FENCE): NOP, pc_SEL=0.
- MEM, load:
  - Drives rs2_SEL=1, imm_SEL=0, ADD, addrs_SEL=0, mem_RE=1, mem_in_EN=1, mem_size=funct3.
  - On mem_ready: reg_SEL=0, reg_WE=1, pc_EN=1, pc_SEL=0; go to FETCH.
- MEM, store:
  - Drives imm_SEL=1, rs2_SEL=1, ADD, addrs_SEL=0, ALU_MEM_EN=1, mem_WE=1, mem_size=funct3.
  - On mem_ready: pc_EN=1, pc_SEL=0; go to FETCH.
- reg_WE and pc_EN are never asserted while waiting for mem_ready.
- Bus exclusivity: mem_in_EN and ALU_mem_EN are never high in the same cycle.
- Wait counter:
  - Cleared on every state entry.
  - Increments each cycle FETCH or MEM waits.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT with mem_ready=0, go to TRAP.
  - mem_ready in that same cycle wins over the timeout.
- TRAP: halted=1, all other outputs 0; exited only by reset.
- Writes with rd=x0 are issued normally; the register file ignores them.
- Latency with a zero-wait memory: 3 cycles for every instruction.

Test Plan:
- Reset held 2 cycles, then release with mem_ready=1 -> all outputs 0 during reset; FETCH asserts mem_RE=1, addrs_SEL=1, instr_EN=1 on the first post-reset cycle.
- instr=0x00208033 (add x0,x1,x2) with zero-wait memory -> EXEC cycle shows ALU_MODE=0, reg_SEL=1, reg_WE=1, pc_EN=1, pc_SEL=0; next FETCH 3 cycles after the previous one.
- instr=0x00208463 (beq) with jump=1, then jump=0 -> pc_SEL=2, then pc_SEL=0, with ALU_MODE=10 and reg_WE=0 in both cases.
- sw, instr=0x0020A223, with mem_ready low for 3 cycles -> ALU_mem_EN=1, mem_WE=1, mem_size=010 held for 4 cycles; pc_EN=1 only in the ready cycle; mem_in_EN=0 throughout.
- lw with MEM_TIMEOUT=4 and mem_ready never asserted -> TRAP entered after 4 wait cycles, halted=1 held until reset.
- instr=0x00000073 (ecall) and instr=0xFFFFFFFF -> DECODE then TRAP; no reg_WE or pc_EN pulse ever issued.
